main_memory_responder: RTL

Backing-store responder at the far end of the cache's miss/write-through path: the memory system issues block-read and byte-write requests and this block answers them after a fixed access latency. It holds the 64-byte architectural memory image (6-bit byte address, 4-byte blocks). It also provides the Busy/Ready handshake the cache controller stalls on.

---
 rtl/main_memory_responder_if.sv | 20 ++
 rtl/main_memory_responder.sv | 76 +++++++
 2 files changed

// File: rtl/main_memory_responder_if.sv
// Request/response bus between the memory system and the backing-store responder.
interface main_memory_responder_if;
  logic        Req;
  logic        RWB;
  logic [5:0]  Address;
  logic [7:0]  Data;
  logic        Busy;
  logic        Ready;
  logic [31:0] BlockOut;

  modport master (
    output Req, RWB, Address, Data,
    input  Busy, Ready, BlockOut
  );

  modport slave (
    input  Req, RWB, Address, Data,
    output Busy, Ready, BlockOut
  );
endinterface

// File: rtl/main_memory_responder.sv
// Backing-store responder: 64-byte memory image answering block reads and
// byte writes after a fixed latency, with a Busy/Ready handshake.
module main_memory_responder #(
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned BLOCK_BYTES = 4
) (
  input logic                    clk,
  input logic                    reset,
  main_memory_responder_if.slave bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                       state;
  logic [3:0]                   cnt;
  logic                         busy_q;
  logic                         ready_q;
  logic [BLOCK_BYTES*8-1:0]     block_q;
  logic                         lat_rwb;
  logic [5:0]                   lat_addr;
  logic [7:0]                   lat_data;
  logic [7:0]                   mem [64];

  assign bus.Busy     = busy_q;
  assign bus.Ready    = ready_q;
  assign bus.BlockOut = block_q;

  // Request acceptance, latency countdown, memory access and registered handshake.
  // Memory shares the async reset because reset must restore the image mem[i] = i.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      block_q  <= '0;
      lat_rwb  <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      for (int unsigned i = 0; i < 64; i++) begin
        mem[i] <= 8'(i);
      end
    end else begin
      ready_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.Req) begin
            lat_rwb  <= bus.RWB;
            lat_addr <= bus.Address;
            lat_data <= bus.Data;
            cnt      <= 4'(LATENCY - 1);
            busy_q   <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (lat_rwb) begin
              block_q <= {mem[{lat_addr[5:2], 2'd3}], mem[{lat_addr[5:2], 2'd2}],
                          mem[{lat_addr[5:2], 2'd1}], mem[{lat_addr[5:2], 2'd0}]};
            end else begin
              mem[lat_addr] <= lat_data;
            end
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
